// File: rtl/spike_rate_decoder.sv
// Spike-train read-out: counts spikes over a programmable window and tracks the
// most recent inter-spike interval; each closed window lands in a valid/ready output register.
module spike_rate_decoder #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] win_len,
    output logic [CNT_W-1:0] rate_out,
    output logic [CNT_W-1:0] isi_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic {S_IDLE, S_COUNT} state_t;

    localparam logic [CNT_W-1:0] C_MAX = '1;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIN_W-1:0] r_win_len;
    logic [WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_spk_cnt;
    logic [CNT_W-1:0] r_isi_cnt;
    logic [CNT_W-1:0] r_isi_last;
    logic             r_seen;
    logic [CNT_W-1:0] r_rate;
    logic [CNT_W-1:0] r_isi_out;
    logic             r_valid;
    logic             r_overrun;

    logic             w_start;
    logic             w_sample;
    logic             w_close;
    logic             w_xfer;
    logic [CNT_W-1:0] w_spk_next;
    logic [CNT_W-1:0] w_isi_last_next;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (enable)  w_state_next = S_COUNT;
            S_COUNT: if (!enable) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // A stored length of 0 wraps L-1 to all-ones, giving a 2^WIN_W cycle window.
    assign w_start  = (r_state == S_IDLE) && enable;
    assign w_sample = (r_state == S_COUNT) && enable;
    assign w_close  = w_sample && (r_win_cnt == (r_win_len - WIN_W'(1)));
    assign w_xfer   = r_valid && out_ready;

    assign w_spk_next = (spike_in && (r_spk_cnt != C_MAX)) ? r_spk_cnt + CNT_W'(1) : r_spk_cnt;
    assign w_isi_last_next = (spike_in && r_seen)
                           ? ((r_isi_cnt == C_MAX) ? C_MAX : r_isi_cnt + CNT_W'(1))
                           : r_isi_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_len  <= '0;
            r_win_cnt  <= '0;
            r_spk_cnt  <= '0;
            r_isi_cnt  <= '0;
            r_isi_last <= '0;
            r_seen     <= 1'b0;
            r_rate     <= '0;
            r_isi_out  <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_start || w_close) begin
                r_win_len <= win_len;
                r_win_cnt <= '0;
                r_spk_cnt <= '0;
            end else if (w_sample) begin
                r_win_cnt <= r_win_cnt + WIN_W'(1);
                r_spk_cnt <= w_spk_next;
            end

            // ISI tracking only lives while sampling; leaving COUNT forgets the previous spike.
            if (w_sample) begin
                r_isi_last <= w_isi_last_next;
                if (spike_in) begin
                    r_isi_cnt <= '0;
                    r_seen    <= 1'b1;
                end else if (r_isi_cnt != C_MAX) begin
                    r_isi_cnt <= r_isi_cnt + CNT_W'(1);
                end
            end else begin
                r_isi_cnt <= '0;
                r_seen    <= 1'b0;
            end

            if (w_close) begin
                if (!r_valid || w_xfer) begin
                    r_rate    <= w_spk_next;
                    r_isi_out <= w_isi_last_next;
                    r_valid   <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rate_out  = r_rate;
    assign isi_out   = r_isi_out;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;
    assign busy      = (r_state == S_COUNT);

endmodule
